digiota_decimator: RTL and testbench

Decimating ones-counter directly downstream of the digital OTA comparator. Takes the asynchronous 1-bit comparator output, synchronises it and rejects single-cycle glitches, then counts ones over a fixed window of 2^OSR_LOG2 clocks. Each completed window's count is presented on a valid/ready output port, giving a multi-bit density/PDM sample for the readout logic.

---
 rtl/digiota_pkg.sv | 23 ++
 rtl/digiota_sync_filter.sv | 42 ++++
 rtl/digiota_decimator.sv | 127 ++++++++++++
 tb/tb_digiota_decimator.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/digiota_pkg.sv
// digiota_pkg
//   Shared definitions for the digital OTA decimator.
//   - OSR_LOG2_DEFAULT : default log2 of the decimation window length
//   - out_state_e      : output register occupancy states
//   - maj3()           : 3-input majority vote used by the glitch filter
package digiota_pkg;

    // Default window is 2^8 = 256 clocks.
    localparam int unsigned OSR_LOG2_DEFAULT = 8;

    // Output register: EMPTY holds a stale (already consumed) value,
    // FULL holds a result not yet accepted by the consumer.
    typedef enum logic [0:0] {
        StEmpty = 1'b0,
        StFull  = 1'b1
    } out_state_e;

    // Majority of three bits: true when at least two inputs are high.
    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[1] & v[2]) | (v[0] & v[2]);
    endfunction

endpackage

// File: rtl/digiota_sync_filter.sv
// digiota_sync_filter
//   Brings the asynchronous comparator output into the clk domain and
//   removes single-cycle glitches with a 3-tap majority vote.
//
// Ports
//   clk    in  1  rising-edge clock
//   rst    in  1  synchronous, active-high reset
//   cmp_in in  1  raw comparator output, asynchronous to clk
//   bit_f  out 1  filtered comparator bit, combinational from the history
module digiota_sync_filter
    import digiota_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic cmp_in,
    output logic bit_f
);

    // Two-flop synchroniser; s1_q may go metastable, s2_q is the first
    // value safe to use in logic.
    logic       s1_q;
    logic       s2_q;
    // Most recent synchronised sample sits in h_q[0].
    logic [2:0] h_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            h_q  <= 3'b000;
        end else begin
            s1_q <= cmp_in;
            s2_q <= s1_q;
            h_q  <= {h_q[1:0], s2_q};
        end
    end

    // A one-clock pulse occupies only one of the three history taps, so it
    // can never win the vote.
    assign bit_f = maj3(h_q);

endmodule

// File: rtl/digiota_decimator.sv
// digiota_decimator
//   Decimating ones-counter for the digital OTA comparator. Counts filtered
//   ones over windows of 2^OSR_LOG2 enabled clocks and presents each window
//   count on a valid/ready port. A result arriving while the previous one is
//   still unconsumed overwrites it and sets the sticky overrun flag.
//
// Parameters
//   OSR_LOG2  window length is 2^OSR_LOG2 clocks (2..16)
//   OUT_W     result width, must hold the full-scale value 2^OSR_LOG2
//
// Ports
//   clk        in  1      rising-edge clock
//   rst        in  1      synchronous, active-high reset
//   cmp_in     in  1      comparator output, asynchronous to clk
//   enable     in  1      window counting enable; low discards the window
//   out_data   out OUT_W  completed window count (held while empty)
//   out_valid  out 1      out_data holds an unconsumed result
//   out_ready  in  1      consumer accepts out_data when out_valid is high
//   overrun    out 1      sticky: a result was overwritten unaccepted
module digiota_decimator
    import digiota_pkg::*;
#(
    parameter int unsigned OSR_LOG2 = OSR_LOG2_DEFAULT,
    parameter int unsigned OUT_W    = OSR_LOG2 + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmp_in,
    input  logic             enable,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun
);

    localparam logic [OSR_LOG2-1:0] PhaseOne = OSR_LOG2'(1);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic bit_f;

    digiota_sync_filter u_sync_filter (
        .clk    (clk),
        .rst    (rst),
        .cmp_in (cmp_in),
        .bit_f  (bit_f)
    );

    // ------------------------------------------------------------------
    // Window counter
    // ------------------------------------------------------------------
    logic [OSR_LOG2-1:0] phase_q;
    logic [OSR_LOG2-1:0] phase_d;
    logic [OUT_W-1:0]    acc_q;
    logic [OUT_W-1:0]    acc_d;
    logic [OUT_W-1:0]    acc_sum;
    logic                win_end;

    // The last sample of a window is folded straight into the result, so the
    // full-scale count 2^OSR_LOG2 appears on the port without ever being
    // stored in acc_q.
    assign acc_sum = acc_q + {{(OUT_W-1){1'b0}}, bit_f};
    assign win_end = enable && (phase_q == '1);

    always_comb begin
        phase_d = '0;
        acc_d   = '0;
        if (enable) begin
            // Phase wraps naturally to 0 after the all-ones value.
            phase_d = phase_q + PhaseOne;
            acc_d   = win_end ? '0 : acc_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
            acc_q   <= '0;
        end else begin
            phase_q <= phase_d;
            acc_q   <= acc_d;
        end
    end

    // ------------------------------------------------------------------
    // Output register and handshake
    // ------------------------------------------------------------------
    out_state_e       state_q;
    logic [OUT_W-1:0] out_data_q;
    logic             overrun_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StEmpty;
            out_data_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (win_end) begin
                        out_data_q <= acc_sum;
                        state_q    <= StFull;
                    end
                end
                StFull: begin
                    if (win_end) begin
                        // Accepted-and-replaced in the same edge is a clean
                        // hand-over; otherwise the old result is lost.
                        out_data_q <= acc_sum;
                        if (!out_ready) begin
                            overrun_q <= 1'b1;
                        end
                    end else if (out_ready) begin
                        state_q <= StEmpty;
                    end
                end
                default: state_q <= StEmpty;
            endcase
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = (state_q == StFull);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_digiota_decimator.sv
// tb_digiota_decimator
//   Self-checking bench for digiota_decimator with a 16-clock window.
//   Table rows describe comparator patterns and the window counts they must
//   produce; expected counts go into a scoreboard queue as a scenario starts
//   and are popped as the DUT hands results over. Overrun, enable-abort and
//   mid-window reset are covered by directed sequences.
module tb_digiota_decimator;

    localparam int unsigned OsrLog2 = 4;
    localparam int unsigned OutW    = OsrLog2 + 1;
    localparam int unsigned Win     = 1 << OsrLog2;

    logic            clk;
    logic            rst;
    logic            cmp_in;
    logic            enable;
    logic [OutW-1:0] out_data;
    logic            out_valid;
    logic            out_ready;
    logic            overrun;

    digiota_decimator #(
        .OSR_LOG2 (OsrLog2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmp_in    (cmp_in),
        .enable    (enable),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned tests;
    int unsigned fails;
    int unsigned cyc;

    always @(posedge clk) cyc <= cyc + 1;

    // Comparator patterns.
    localparam int unsigned PatHigh   = 0;
    localparam int unsigned PatToggle = 1;
    localparam int unsigned PatPulse5 = 2;

    typedef struct {
        string           name;
        int unsigned     pat;
        int unsigned     n_res;
        bit              chk_first;
        logic [OutW-1:0] first;
        logic [OutW-1:0] steady;
    } scen_t;

    typedef struct {
        logic [OutW-1:0] val;
        bit              chk_val;
        bit              chk_gap;
    } exp_t;

    scen_t       scen [3];
    exp_t        sb [$];
    bit          mon_en;
    int unsigned last_xfer;

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic pat_bit(input int unsigned pat, input int unsigned k);
        case (pat)
            PatToggle: return (k % 2) == 0;
            PatPulse5: return (k % 5) == 0;
            default:   return 1'b1;
        endcase
    endfunction

    // Scoreboard consumer: a transfer happens at the next rising edge.
    always @(negedge clk) begin
        if (mon_en && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.chk_val) check("result_value", out_data, e.val);
                if (e.chk_gap) check("result_spacing", cyc - last_xfer, Win);
            end
            last_xfer = cyc;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_overrun", overrun, 0);
        rst = 1'b0;
    endtask

    task automatic run_scen(input int unsigned i);
        exp_t e;
        int unsigned ncyc;
        enable    = 1'b1;
        out_ready = 1'b1;
        cmp_in    = pat_bit(scen[i].pat, 0);
        do_reset();
        sb.delete();
        for (int r = 0; r < int'(scen[i].n_res); r++) begin
            e.val     = (r == 0) ? scen[i].first : scen[i].steady;
            e.chk_val = (r != 0) || scen[i].chk_first;
            e.chk_gap = (r != 0);
            sb.push_back(e);
        end
        mon_en = 1'b1;
        ncyc = scen[i].n_res * Win + 4;
        for (int unsigned k = 0; k < ncyc; k++) begin
            cmp_in = pat_bit(scen[i].pat, k);
            tick(1);
        end
        mon_en = 1'b0;
        check({scen[i].name, "_results_left"}, sb.size(), 0);
        check({scen[i].name, "_overrun"}, overrun, 0);
    endtask

    initial begin
        bit early;
        tests     = 0;
        fails     = 0;
        cyc       = 0;
        mon_en    = 1'b0;
        last_xfer = 0;
        rst       = 1'b1;
        cmp_in    = 1'b0;
        enable    = 1'b1;
        out_ready = 1'b1;

        scen[0] = '{name: "high",   pat: PatHigh,   n_res: 4, chk_first: 1'b1,
                    first: OutW'(12), steady: OutW'(16)};
        scen[1] = '{name: "toggle", pat: PatToggle, n_res: 4, chk_first: 1'b0,
                    first: OutW'(0),  steady: OutW'(8)};
        scen[2] = '{name: "pulse5", pat: PatPulse5, n_res: 4, chk_first: 1'b1,
                    first: OutW'(0),  steady: OutW'(0)};

        tick(2);
        for (int unsigned i = 0; i < 3; i++) run_scen(i);

        // Overrun: consumer stalled across two windows.
        cmp_in    = 1'b1;
        enable    = 1'b1;
        out_ready = 1'b0;
        do_reset();
        tick(15);
        check("ovr_not_yet_valid", out_valid, 0);
        tick(1);
        check("ovr_first_valid", out_valid, 1);
        check("ovr_first_data", out_data, 12);
        check("ovr_first_no_overrun", overrun, 0);
        tick(16);
        check("ovr_second_data", out_data, 16);
        check("ovr_second_overrun", overrun, 1);
        tick(9);
        check("ovr_stall_valid", out_valid, 1);
        check("ovr_stall_data", out_data, 16);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check("ovr_after_pulse_valid", out_valid, 0);
        check("ovr_after_pulse_sticky", overrun, 1);
        tick(6);
        check("ovr_next_valid", out_valid, 1);
        check("ovr_next_data", out_data, 16);
        tick(16);
        check("ovr_later_sticky", overrun, 1);

        // Enable dropped for 5 clocks mid-window.
        out_ready = 1'b1;
        do_reset();
        tick(16);
        check("en_first_data", out_data, 12);
        tick(1);
        check("en_taken_valid", out_valid, 0);
        check("en_hold_data", out_data, 12);
        tick(3);
        enable = 1'b0;
        tick(5);
        enable = 1'b1;
        early = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick(1);
            if (out_valid) early = 1'b1;
        end
        check("en_no_early_result", early, 0);
        tick(1);
        check("en_result_valid", out_valid, 1);
        check("en_result_data", out_data, 16);

        // Reset 7 clocks into the second window, then the high pattern again.
        do_reset();
        tick(Win + 7);
        check("rst_pre_hold_data", out_data, 12);
        run_scen(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
